sm_result_stage: RTL and testbench
==================================

# sm_result_stage

Result-capture stage that sits directly downstream of the 16-bit sign-magnitude add/subtract unit in the execute path. It accepts the unit's 32-bit result word and its cout/zero/overflow/neg flags, canonicalises the sign-magnitude encoding, and buffers results in a small FIFO toward writeback with a valid/ready handshake. It also maintains the architectural NZCV flag register, updated only when a flag-setting result is consumed by writeback.

## Interface
- N, 32, result word width; only bits [15:0] carry data (bit 15 sign, [14:0] magnitude)
- DEPTH, 4, FIFO entries; power of two, 2..16

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute result present
- in_ready  out  1  stage can accept this cycle
- in_result  in  N  result word from the sign-magnitude unit
- in_cout  in  1  carry-out flag
- in_zero  in  1  zero flag
- in_overflow  in  1  overflow flag
- in_neg  in  1  negative flag
- in_rd  in  4  destination register index
- in_setflags  in  1  this result updates NZCV
- flush  in  1  discard all buffered results
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback accepts head
- out_result  out  N  canonical result word
- out_rd  out  4  destination of head entry
- flags_nzcv  out  4  {N,Z,C,V} architectural flags
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. No combinational path from out_ready to in_ready; when full, a same-cycle pop does not admit a push.
- Canonicalisation at push:
  - Bits [N-1:16] are forced to 0.
  - If in_result[14:0] == 0, bit 15 is forced to 0, so -0 becomes +0.
  - The stored entry holds: canonical word, rd, setflags, and flags {neg', zero, cout, overflow}.
  - neg' = canonical bit 15, not in_neg.
  - zero is recomputed as canonical[14:0] == 0; in_zero is ignored.
- Entries pop in push order. The FIFO uses read/write pointers of width $clog2(DEPTH) and wraps modulo DEPTH.
- Simultaneous push and pop:
  - Allowed when 0 < count < DEPTH; count is unchanged.
  - At count == 0 a pop cannot occur, because out_valid is low.
- On pop with setflags = 1: flags_nzcv <= stored flags on that clock edge. With setflags = 0, flags_nzcv holds.
- Flush:
  - At the next edge, pointers and count go to 0.
  - Any pop in the flush cycle still completes its writeback handshake and updates flags.
  - Any push in the flush cycle is blocked, because in_ready is low.
- out_result and out_rd are driven to 0 whenever out_valid = 0.

## Timing
- Reset (asynchronous assert, synchronous deassert at the edge):
  - count = 0, out_valid = 0, out_result = 0, out_rd = 0, flags_nzcv = 4'b0000.
  - Pointers = 0.
  - in_ready = 1 on the first cycle after reset if flush is low.
- Latency: a result pushed at edge k is visible on out_valid/out_result after edge k (earliest pop at edge k+1). There is no same-cycle bypass.
- out_valid = (count != 0), decoded from registered state.
- flags_nzcv changes only on the pop edge of a flag-setting entry.
- Reset mid-operation discards all entries and clears the flags immediately.
- Sustained throughput is one result per cycle when out_ready is held high.

## Test plan
- Canonical -0: push in_result=32'h0000_8000, setflags=1, pop -> out_result=32'h0000_0000, flags_nzcv=4'b0100.
- Upper-bit scrub: push 32'hABCD_8005 with cout=1, setflags=1 -> out_result=32'h0000_8005, flags_nzcv after pop=4'b1010.
- Fill and back-pressure: out_ready=0, push 4 results (DEPTH=4) -> count=4, in_ready=0. Then out_ready=1 with in_valid held -> a 5th push is accepted only after the first pop edge, and output order is preserved.
- Flags gating: pop a setflags=0 entry with neg=1 -> flags_nzcv unchanged. Next pop a setflags=1 entry with 32'h0000_0003 -> flags_nzcv=4'b0000.
- Flush with simultaneous pop: count=3, flush=1, out_ready=1 -> head pops and updates flags, the next cycle has count=0, and the push that cycle is blocked.
- Async reset mid-stream: assert rst between edges with count=2 and flags=4'b1000 -> out_valid=0, count=0, flags_nzcv=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sm_result_stage.sv
// sm_result_stage
// ---------------
// Result-capture stage behind the 16-bit sign-magnitude add/subtract unit.
// Each accepted result is canonicalised (upper bits scrubbed, -0 folded to
// +0, N and Z recomputed from the canonical word) and buffered in a small
// FIFO toward writeback. The architectural NZCV register is updated when
// writeback consumes an entry that was marked flag-setting.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Push = in_valid && in_ready, pop = out_valid && out_ready.
// in_ready is decoded from registered occupancy and flush only, so it never
// depends on out_ready in the same cycle.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake
//   in_result       N-bit result word; only [15:0] carries data
//   in_cout, in_zero, in_overflow, in_neg, in_rd, in_setflags
//                   flags and metadata from the unit (in_zero and in_neg
//                   are recomputed here from the canonical word)
//   flush           discard all buffered entries at the next edge
//   out_valid/ready downstream (writeback) handshake
//   out_result      canonical result word of the head entry, 0 when idle
//   out_rd          destination of the head entry, 0 when idle
//   flags_nzcv      architectural {N,Z,C,V}
//   count           occupied entries
module sm_result_stage #(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N-1:0]               in_result,
   input  logic                       in_cout,
   input  logic                       in_zero,
   input  logic                       in_overflow,
   input  logic                       in_neg,
   input  logic [3:0]                 in_rd,
   input  logic                       in_setflags,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N-1:0]               out_result,
   output logic [3:0]                 out_rd,
   output logic [3:0]                 flags_nzcv,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Entry storage. Only the 16 data bits are kept; the upper bits of the
   // canonical word are always zero and are rebuilt on the output.
   logic [15:0]   word_q [DEPTH];
   logic [15:0]   word_d [DEPTH];
   logic [3:0]    rd_q   [DEPTH];
   logic [3:0]    rd_d   [DEPTH];
   logic          sf_q   [DEPTH];
   logic          sf_d   [DEPTH];
   logic [3:0]    flg_q  [DEPTH];
   logic [3:0]    flg_d  [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    nzcv_q, nzcv_d;

   logic [14:0]   canon_mag;
   logic          canon_sign;
   logic          canon_zero;
   logic          push;
   logic          pop;

   // The unit's own zero/neg flags and the upper result bits are
   // deliberately not used: N and Z come from the canonical word.
   logic          unused_inputs;
   assign unused_inputs = ^{in_zero, in_neg, in_result[N-1:16]};

   assign in_ready   = (count_q < CW'(DEPTH)) && !flush;
   assign out_valid  = (count_q != '0);
   assign out_result = out_valid ? {{(N-16){1'b0}}, word_q[rd_ptr_q]} : '0;
   assign out_rd     = out_valid ? rd_q[rd_ptr_q] : 4'd0;
   assign flags_nzcv = nzcv_q;
   assign count      = count_q;

   // Canonical form: a zero magnitude always carries a positive sign.
   assign canon_mag  = in_result[14:0];
   assign canon_zero = (canon_mag == 15'd0);
   assign canon_sign = in_result[15] && !canon_zero;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      word_d   = word_q;
      rd_d     = rd_q;
      sf_d     = sf_q;
      flg_d    = flg_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      nzcv_d   = nzcv_q;

      if (push) begin
         word_d[wr_ptr_q] = {canon_sign, canon_mag};
         rd_d[wr_ptr_q]   = in_rd;
         sf_d[wr_ptr_q]   = in_setflags;
         flg_d[wr_ptr_q]  = {canon_sign, canon_zero, in_cout, in_overflow};
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (sf_q[rd_ptr_q]) begin
            nzcv_d = flg_q[rd_ptr_q];
         end
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Flush wins over pointer/count bookkeeping, but a pop in the same
      // cycle has already committed its flag update above.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            rd_q[i]   <= '0;
            sf_q[i]   <= 1'b0;
            flg_q[i]  <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         nzcv_q   <= 4'b0000;
      end else begin
         word_q   <= word_d;
         rd_q     <= rd_d;
         sf_q     <= sf_d;
         flg_q    <= flg_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         nzcv_q   <= nzcv_d;
      end
   end

endmodule

// File: tb/tb_sm_result_stage.sv
// Testbench for sm_result_stage: directed vectors, expected results pushed
// into exp_q on each accepted push, popped and compared by a monitor on
// every writeback handshake. Flags, count and ready are checked inline.
module tb_sm_result_stage;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_result;
   logic          in_cout;
   logic          in_zero;
   logic          in_overflow;
   logic          in_neg;
   logic [3:0]    in_rd;
   logic          in_setflags;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_result;
   logic [3:0]    out_rd;
   logic [3:0]    flags_nzcv;
   logic [CW-1:0] count;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [N+3:0]  exp_q[$];
   logic [N+3:0]  mon_exp;

   sm_result_stage #(.N(N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_cout     (in_cout),
      .in_zero     (in_zero),
      .in_overflow (in_overflow),
      .in_neg      (in_neg),
      .in_rd       (in_rd),
      .in_setflags (in_setflags),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .flags_nzcv  (flags_nzcv),
      .count       (count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got %h rd %h expected no entry", out_result, out_rd);
         end else begin
            mon_exp = exp_q.pop_front();
            check("pop_result", out_result, mon_exp[N+3:4]);
            check("pop_rd", {28'd0, out_rd}, {28'd0, mon_exp[3:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Entered and left at posedge+1. Holds in_valid until accepted.
   task automatic push(input logic [N-1:0] res, input logic [3:0] rd, input logic sf,
                       input logic c, input logic v, input logic ng, input logic z,
                       input logic [N-1:0] exp_word);
      int budget;
      budget      = 0;
      in_result   = res;
      in_rd       = rd;
      in_setflags = sf;
      in_cout     = c;
      in_overflow = v;
      in_neg      = ng;
      in_zero     = z;
      in_valid    = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back({exp_word, rd});
            @(posedge clk);
            #1;
            break;
         end
         budget++;
         if (budget > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready 0 expected 1");
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      check("pop_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_cout = 1'b0; in_zero = 1'b0;
      in_overflow = 1'b0; in_neg = 1'b0; in_rd = '0; in_setflags = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_rd", {28'd0, out_rd}, 32'd0);
      check("rst_flags", {28'd0, flags_nzcv}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // -0 folds to +0; Z recomputed even though in_zero is low
      push(32'h0000_8000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
      check("neg0_count", {29'd0, count}, 32'd1);
      pop_one();
      check("neg0_flags", {28'd0, flags_nzcv}, 32'h4);

      // upper bits scrubbed; N from canonical bit 15 even though in_neg is low
      push(32'hABCD_8005, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_8005);
      pop_one();
      check("scrub_flags", {28'd0, flags_nzcv}, 32'hA);

      // flags gating: setflags=0 entry leaves NZCV alone
      push(32'h0000_8001, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_8001);
      push(32'h0000_0003, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0003);
      pop_one();
      check("gate_hold_flags", {28'd0, flags_nzcv}, 32'hA);
      pop_one();
      check("gate_set_flags", {28'd0, flags_nzcv}, 32'h0);

      // fill and back-pressure
      push(32'h0000_0011, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0011);
      push(32'h0000_8022, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_8022);
      push(32'hFFFF_8000, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
      push(32'h0000_0044, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044);
      check("full_count", {29'd0, count}, 32'd4);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      in_result = 32'h0000_7FFF; in_rd = 4'd9; in_setflags = 1'b1; in_cout = 1'b1;
      in_overflow = 1'b1; in_neg = 1'b0; in_zero = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("full_pop_no_push", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("after_pop_count", {29'd0, count}, 32'd3);
      @(negedge clk);
      check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back({32'h0000_7FFF, 4'd9});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("push_pop_count", {29'd0, count}, 32'd3);
      budget = 0;
      while (count != 0 && budget < 20) begin
         @(posedge clk);
         #1;
         budget++;
      end
      out_ready = 1'b0;
      check("drain_count", {29'd0, count}, 32'd0);
      check("drain_flags", {28'd0, flags_nzcv}, 32'h3);

      // flush with simultaneous pop
      push(32'h0000_8010, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_8010);
      push(32'h0000_0020, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
      push(32'h0000_0030, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0030);
      check("flush_pre_count", {29'd0, count}, 32'd3);
      flush = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_result = 32'h0000_0055; in_rd = 4'd15; in_setflags = 1'b1;
      @(negedge clk);
      check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("flush_count", {29'd0, count}, 32'd0);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_out_result", out_result, 32'd0);
      check("flush_flags", {28'd0, flags_nzcv}, 32'h8);

      // asynchronous reset mid-stream
      push(32'h0000_0040, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040);
      push(32'h0000_0050, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0050);
      check("areset_pre_count", {29'd0, count}, 32'd2);
      check("areset_pre_flags", {28'd0, flags_nzcv}, 32'h8);
      #2 rst = 1'b1;
      #1;
      check("areset_out_valid", {31'd0, out_valid}, 32'd0);
      check("areset_count", {29'd0, count}, 32'd0);
      check("areset_flags", {28'd0, flags_nzcv}, 32'h0);
      check("areset_out_rd", {28'd0, out_rd}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

      // operation after reset, V flag path
      push(32'h0000_8007, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_8007);
      pop_one();
      check("post_reset_flags", {28'd0, flags_nzcv}, 32'h9);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
